// File: rtl/ads4129_align.sv
// ads4129_align: link-training controller for one ADS4129 LVDS capture channel.
// Define ADS4129_ALIGN_TAP_SWEEP_EN to compile in the per-lane IDELAY tap sweep.
module ads4129_align #(
    parameter logic [11:0] P_PATTERN_0 = 12'h6C9,
    parameter logic [11:0] P_PATTERN_1 = 12'h36A,
    parameter int unsigned P_SETTLE    = 16,
    parameter int unsigned P_CHECK_LEN = 64,
    parameter int unsigned P_MAX_TAP   = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] sample_0,
    input  logic [11:0] sample_1,
    output logic        io_reset,
    output logic        in_delay_reset,
    output logic [5:0]  bitslip,
    output logic [5:0]  in_delay_ce,
    output logic [5:0]  in_delay_inc,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [5:0]  lane_ok
);

    localparam int unsigned NLANE     = 6;
    localparam int unsigned RESET_LEN = 4;
    localparam int unsigned CNT_MAX   = (P_SETTLE > P_CHECK_LEN) ? P_SETTLE : P_CHECK_LEN;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SETTLE,
        S_CHECK,
        S_ADJUST,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NLANE-1:0]        err_q, err_d;
    logic [NLANE-1:0]        lane_ok_q, lane_ok_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;
    logic [NLANE-1:0][1:0]   slip_q, slip_d;

    logic [NLANE-1:0]        mism;
    logic [NLANE-1:0]        slip_req;
    logic                    exhausted;
    logic                    adjust_go;

`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
    localparam logic [4:0]   TAP_LIM = 5'(P_MAX_TAP);
    logic [NLANE-1:0][4:0]   tap_q, tap_d;
    logic [NLANE-1:0]        step_req;
`else
    logic                    unused_max_tap;
    assign unused_max_tap = (P_MAX_TAP != 0);
`endif

    // Lane k owns bits {2k+1, 2k} of both sample words.
    always_comb begin
        mism = '0;
        for (int unsigned k = 0; k < NLANE; k++) begin
            mism[k] = (sample_0[2*k +: 2] != P_PATTERN_0[2*k +: 2]) ||
                      (sample_1[2*k +: 2] != P_PATTERN_1[2*k +: 2]);
        end
    end

    // Per failing lane: slip through the 4 word positions, then step one tap.
    always_comb begin
        slip_req  = '0;
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
        step_req  = '0;
`endif
        exhausted = 1'b0;
        for (int unsigned k = 0; k < NLANE; k++) begin
            if (!lane_ok_q[k]) begin
                if (slip_q[k] != 2'd3) begin
                    slip_req[k] = 1'b1;
                end
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
                else if (tap_q[k] >= TAP_LIM) begin
                    exhausted = 1'b1;
                end else begin
                    step_req[k] = 1'b1;
                end
`else
                else begin
                    exhausted = 1'b1;
                end
`endif
            end
        end
    end

    assign adjust_go = (state_q == S_ADJUST) && !exhausted;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        lane_ok_d = lane_ok_q;
        done_d    = done_q;
        fail_d    = fail_q;
        slip_d    = slip_q;
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
        tap_d     = tap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    lane_ok_d = '0;
                    slip_d    = '0;
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
                    tap_d     = '0;
`endif
                    cnt_d     = '0;
                    state_d   = S_RESET;
                end
            end
            S_RESET: begin
                if (cnt_q == CNT_W'(RESET_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(P_SETTLE - 1)) begin
                    cnt_d   = '0;
                    err_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                err_d = err_q | mism;
                if (cnt_q == CNT_W'(P_CHECK_LEN - 1)) begin
                    cnt_d     = '0;
                    lane_ok_d = ~(err_q | mism);
                    if ((err_q | mism) == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADJUST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ADJUST: begin
                if (exhausted) begin
                    fail_d  = 1'b1;
                    state_d = S_FAIL;
                end else begin
                    for (int unsigned k = 0; k < NLANE; k++) begin
                        if (slip_req[k]) begin
                            slip_d[k] = slip_q[k] + 2'd1;
                        end
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
                        if (step_req[k]) begin
                            slip_d[k] = '0;
                            tap_d[k]  = tap_q[k] + 5'd1;
                        end
`endif
                    end
                    state_d = S_SETTLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= '0;
            lane_ok_q <= '0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            slip_q    <= '0;
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
            tap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            lane_ok_q <= lane_ok_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            slip_q    <= slip_d;
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
            tap_q     <= tap_d;
`endif
        end
    end

    assign io_reset       = (state_q == S_RESET);
    assign in_delay_reset = (state_q == S_RESET);
    assign busy           = state_q inside {S_RESET, S_SETTLE, S_CHECK, S_ADJUST};
    assign done           = done_q;
    assign fail           = fail_q;
    assign lane_ok        = lane_ok_q;
    assign bitslip        = adjust_go ? slip_req : '0;
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
    assign in_delay_ce    = adjust_go ? step_req : '0;
`else
    assign in_delay_ce    = '0;
`endif
    assign in_delay_inc   = in_delay_ce;

endmodule

// File: tb/tb_ads4129_align.sv
// Bench for ads4129_align: emulated capture channel plus an arithmetic model of the search.
module tb_ads4129_align;

    localparam logic [11:0] PAT0   = 12'h6C9;
    localparam logic [11:0] PAT1   = 12'h36A;
    localparam int          SETTLE = 16;
    localparam int          CHK    = 64;
    localparam int          MAXTAP = 2;
    localparam int          SC     = SETTLE + CHK;
`ifdef ADS4129_ALIGN_TAP_SWEEP_EN
    localparam int          LIMIT  = 4 * MAXTAP + 3;
    localparam int          SWEEP  = 1;
`else
    localparam int          LIMIT  = 3;
    localparam int          SWEEP  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] sample_0, sample_1;
    logic        io_reset, in_delay_reset, busy, done, fail;
    logic [5:0]  bitslip, in_delay_ce, in_delay_inc, lane_ok;

    ads4129_align #(
        .P_PATTERN_0 (PAT0),
        .P_PATTERN_1 (PAT1),
        .P_SETTLE    (SETTLE),
        .P_CHECK_LEN (CHK),
        .P_MAX_TAP   (MAXTAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sample_0       (sample_0),
        .sample_1       (sample_1),
        .io_reset       (io_reset),
        .in_delay_reset (in_delay_reset),
        .bitslip        (bitslip),
        .in_delay_ce    (in_delay_ce),
        .in_delay_inc   (in_delay_inc),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .lane_ok        (lane_ok)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tgt_s[6], tgt_t[6];
    bit tgt_never[6];
    int n_lane[6];
    int run_r, end_off;
    bit run_done;
    int off = 0;
    bit track = 1'b0;
    int cnt_bs[6], cnt_ce[6];
    int first_done;
    int phys_s[6], phys_t[6];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t off=%0d)", nm, act, exp_v, $time, off);
        end
    endtask

    // Lane position after p search steps: tap = p/4, slip = (3*tap + p%4) mod 4.
    // Step index of the first match is therefore 4*t + (s + t) mod 4.
    function automatic void model_at(input int o, output int e_io, output int e_busy,
                                     output int e_done, output int e_fail, output int e_bs,
                                     output int e_ce, output int e_ok);
        int c;
        e_io   = (o >= 1 && o <= 4) ? 1 : 0;
        e_busy = (o >= 1 && o < end_off) ? 1 : 0;
        e_done = (run_done && o >= end_off) ? 1 : 0;
        e_fail = (!run_done && o >= end_off) ? 1 : 0;
        e_bs = 0;
        e_ce = 0;
        for (int r = 1; r <= run_r; r++) begin
            if (o == 5 + r * SC + r - 1) begin
                for (int k = 0; k < 6; k++) begin
                    if (r <= n_lane[k]) begin
                        if ((r - 1) % 4 == 3) e_ce = e_ce | (1 << k);
                        else                  e_bs = e_bs | (1 << k);
                    end
                end
            end
        end
        c = 0;
        for (int m = 1; m <= run_r + 1; m++) begin
            if (5 + m * SC + m - 1 <= o) c = m;
        end
        e_ok = 0;
        if (c > 0) begin
            for (int k = 0; k < 6; k++) begin
                if (n_lane[k] <= c - 1) e_ok = e_ok | (1 << k);
            end
        end
    endfunction

    // Emulated capture channel: per-lane word/tap position, 2-cycle output pipeline.
    initial begin
        logic [11:0] st0, st1, r0, r1;
        logic [3:0]  m;
        for (int k = 0; k < 6; k++) begin
            phys_s[k] = $urandom_range(0, 3);
            phys_t[k] = 0;
        end
        st0 = '0;
        st1 = '0;
        sample_0 = '0;
        sample_1 = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 6; k++) begin
                if (io_reset)         phys_s[k] = 0;
                else if (bitslip[k])  phys_s[k] = (phys_s[k] + 1) % 4;
                if (in_delay_reset)       phys_t[k] = 0;
                else if (in_delay_ce[k])  phys_t[k] = phys_t[k] + 1;
            end
            sample_0 = st0;
            sample_1 = st1;
            r0 = PAT0;
            r1 = PAT1;
            for (int k = 0; k < 6; k++) begin
                if (tgt_never[k] || phys_s[k] != tgt_s[k] || phys_t[k] != tgt_t[k]) begin
                    m = 4'($urandom_range(1, 15));
                    r0[2*k +: 2] = r0[2*k +: 2] ^ m[1:0];
                    r1[2*k +: 2] = r1[2*k +: 2] ^ m[3:2];
                end
            end
            st0 = r0;
            st1 = r1;
        end
    end

    // Compare process: every cycle of a tracked run against the model.
    initial begin
        int e_io, e_busy, e_done, e_fail, e_bs, e_ce, e_ok;
        forever begin
            @(posedge clk);
            #2;
            if (track) begin
                off++;
                model_at(off, e_io, e_busy, e_done, e_fail, e_bs, e_ce, e_ok);
                chk("io_reset", io_reset, e_io);
                chk("in_delay_reset", in_delay_reset, e_io);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("fail", fail, e_fail);
                chk("bitslip", bitslip, e_bs);
                chk("in_delay_ce", in_delay_ce, e_ce);
                chk("in_delay_inc", in_delay_inc, e_ce);
                chk("lane_ok", lane_ok, e_ok);
                for (int k = 0; k < 6; k++) begin
                    cnt_bs[k] += bitslip[k] ? 1 : 0;
                    cnt_ce[k] += in_delay_ce[k] ? 1 : 0;
                end
                if (done && first_done < 0) first_done = off;
            end
        end
    end

    task automatic set_aligned();
        for (int k = 0; k < 6; k++) begin
            tgt_s[k] = 0;
            tgt_t[k] = 0;
            tgt_never[k] = 1'b0;
        end
    endtask

    task automatic launch();
        int big;
        big = 0;
        for (int k = 0; k < 6; k++) begin
            n_lane[k] = tgt_never[k] ? 1000 : 4 * tgt_t[k] + (tgt_s[k] + tgt_t[k]) % 4;
            if (n_lane[k] > big) big = n_lane[k];
            cnt_bs[k] = 0;
            cnt_ce[k] = 0;
        end
        run_done   = (big <= LIMIT);
        run_r      = run_done ? big : LIMIT;
        end_off    = 5 + (run_r + 1) * SC + run_r + (run_done ? 0 : 1);
        first_done = -1;
        @(negedge clk);
        start = 1'b1;
        off   = 0;
        track = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input bit poke);
        while (off < end_off + 3) begin
            @(negedge clk);
            start = (poke && off == 40) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        track = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("lane_physically_aligned",
                (!tgt_never[k] && phys_s[k] == tgt_s[k] && phys_t[k] == tgt_t[k]) ? 1 : 0,
                (n_lane[k] <= run_r) ? 1 : 0);
        end
    endtask

    function automatic int pulse_sum(input int skip);
        int s;
        s = 0;
        for (int k = 0; k < 6; k++) begin
            if (k != skip) s += cnt_bs[k] + cnt_ce[k];
        end
        return s;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_aligned();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_fail", fail, 0);
        chk("reset_io_reset", io_reset, 0);
        chk("reset_bitslip", bitslip, 0);
        chk("reset_lane_ok", lane_ok, 0);
        @(negedge clk);
        rst = 1'b0;

        // Already aligned: no pulses, done after 1+4+16+64 cycles.
        set_aligned();
        launch();
        finish_run(1'b0);
        chk("t1_done_latency", first_done, 85);
        chk("t1_lane_ok", lane_ok, 6'h3F);
        chk("t1_pulses", pulse_sum(-1), 0);

        // Lane 2 needs two slips.
        set_aligned();
        tgt_s[2] = 2;
        launch();
        finish_run(1'b0);
        chk("t2_lane2_slips", cnt_bs[2], 2);
        chk("t2_other_pulses", pulse_sum(2), 0);
        chk("t2_done", done, 1);

        // Lane 5 aligned only at tap 2, last reachable position.
        set_aligned();
        tgt_s[5] = 1;
        tgt_t[5] = 2;
        launch();
        finish_run(1'b0);
        chk("t3_lane5_slips", cnt_bs[5], SWEEP ? 9 : 3);
        chk("t3_lane5_ce", cnt_ce[5], SWEEP ? 2 : 0);
        chk("t3_done", done, SWEEP ? 1 : 0);
        chk("t3_fail", fail, SWEEP ? 0 : 1);

        // Lane 0 never matches.
        set_aligned();
        tgt_never[0] = 1'b1;
        launch();
        finish_run(1'b0);
        chk("t4_fail", fail, 1);
        chk("t4_lane_ok", lane_ok, 6'h3E);
        chk("t4_lane0_ce", cnt_ce[0], SWEEP ? 2 : 0);
        chk("t4_lane0_slips", cnt_bs[0], SWEEP ? 9 : 3);

        // Lane 1 never matches.
        set_aligned();
        tgt_never[1] = 1'b1;
        launch();
        finish_run(1'b1);
        chk("t5_lane1_slips", cnt_bs[1], SWEEP ? 9 : 3);
        chk("t5_lane_ok", lane_ok, 6'h3D);

        // rst during SETTLE, then a clean restart.
        set_aligned();
        tgt_s[3] = 1;
        launch();
        while (off < 10) @(negedge clk);
        rst   = 1'b1;
        track = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_io_reset", io_reset, 0);
        chk("rst_in_delay_reset", in_delay_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fail", fail, 0);
        chk("rst_done", done, 0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_ce", in_delay_ce, 0);
        chk("rst_lane_ok", lane_ok, 0);
        @(negedge clk);
        rst = 1'b0;
        launch();
        finish_run(1'b0);
        chk("t6_lane3_slips", cnt_bs[3], 1);

        for (int run = 0; run < 12; run++) begin
            for (int k = 0; k < 6; k++) begin
                tgt_s[k]     = $urandom_range(0, 3);
                tgt_t[k]     = ($urandom_range(0, 2) == 0) ? $urandom_range(0, MAXTAP + 1) : 0;
                tgt_never[k] = ($urandom_range(0, 19) == 0);
            end
            launch();
            finish_run(run % 2 == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
